// File: rtl/l2_arbiter_pkg.sv
// Shared types for the two-master L2 arbiter: FSM states and master identifiers.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    RELEASE
  } arb_state_t;

  typedef logic [0:0] master_id_t;

  localparam master_id_t M_ICACHE = 1'b0;
  localparam master_id_t M_DCACHE = 1'b1;

endpackage

// File: rtl/l2_arbiter_if.sv
// Cache-miss request bus. The requester uses the master modport; the side that
// serves the request (and may ask the requester to retry) uses the slave modport.
interface l2_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);

  logic              stb;
  logic              cyc;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              resp;
  logic              retry;

  modport master (
    output stb, cyc, write, addr, wdata,
    input  rdata, resp
  );

  modport slave (
    input  stb, cyc, write, addr, wdata,
    output rdata, resp, retry
  );

endinterface

// File: rtl/l2_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the master that did not win last time
// is chosen; a lone requester always wins.
module rr_pick2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t lastGrant_i,
  output logic       valid_o,
  output master_id_t winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = M_ICACHE;
    if (req_i == 2'b11) begin
      winner_o = ~lastGrant_i;
    end else if (req_i[1]) begin
      winner_o = M_DCACHE;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the I-cache and D-cache miss paths, with
// round-robin fairness, a release bubble after each grant and a hang watchdog.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  l2_arbiter_if.slave  m0,
  l2_arbiter_if.slave  m1,
  l2_arbiter_if.master l2,
  output logic         timeout_err,
  output master_id_t   grant_id
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arb_state_t        state_q;
  master_id_t        lastGrant_q;
  master_id_t        grantId_q;
  logic [WDOG_W-1:0] wdog_q;

  logic       pickValid;
  master_id_t pickWinner;
  logic       m0Granted, m1Granted, inGrant, curCyc;
  logic       respHit, abortHit, timeoutHit;
  master_id_t curId;

  rr_pick2 u_pick (
    .req_i      ({m1.stb & m1.cyc, m0.stb & m0.cyc}),
    .lastGrant_i(lastGrant_q),
    .valid_o    (pickValid),
    .winner_o   (pickWinner)
  );

  always_comb begin
    m0Granted = (state_q == GRANT0);
    m1Granted = (state_q == GRANT1);
    inGrant   = m0Granted | m1Granted;
    curCyc    = m1Granted ? m1.cyc : m0.cyc;
    curId     = m1Granted ? M_DCACHE : M_ICACHE;

    // Priority inside a grant: resp beats abort, abort beats the watchdog.
    respHit    = inGrant & l2.resp;
    abortHit   = inGrant & ~l2.resp & ~curCyc;
    timeoutHit = inGrant & ~l2.resp & curCyc & (wdog_q == WDOG_LAST);

    l2.stb   = 1'b0;
    l2.cyc   = 1'b0;
    l2.write = 1'b0;
    l2.addr  = '0;
    l2.wdata = '0;
    if (m0Granted) begin
      l2.stb   = m0.stb;
      l2.cyc   = m0.cyc;
      l2.write = m0.write;
      l2.addr  = m0.addr;
      l2.wdata = m0.wdata;
    end else if (m1Granted) begin
      l2.stb   = m1.stb;
      l2.cyc   = m1.cyc;
      l2.write = m1.write;
      l2.addr  = m1.addr;
      l2.wdata = m1.wdata;
    end

    m0.rdata = m0Granted ? l2.rdata : '0;
    m1.rdata = m1Granted ? l2.rdata : '0;
    m0.resp  = m0Granted & l2.resp;
    m1.resp  = m1Granted & l2.resp;
    m0.retry = m0.stb & m0.cyc & ~m0.resp;
    m1.retry = m1.stb & m1.cyc & ~m1.resp;

    timeout_err = timeoutHit;
    grant_id    = grantId_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= M_DCACHE;
      grantId_q   <= M_ICACHE;
      wdog_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            state_q   <= (pickWinner == M_DCACHE) ? GRANT1 : GRANT0;
            grantId_q <= pickWinner;
            wdog_q    <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (respHit | abortHit | timeoutHit) begin
            lastGrant_q <= curId;
            state_q     <= abortHit ? IDLE : RELEASE;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter; inputs change on the falling
// edge and outputs are sampled 1ns later, well away from the rising edge.
module tb_l2_arbiter;
  import l2_arb_pkg::*;

  localparam logic [255:0] RD_PAT  = {8{32'hDEADBEEF}};
  localparam logic [255:0] RD_PAT2 = {8{32'h12345678}};
  localparam logic [255:0] WR_PAT  = {8{32'hA5A5A5A5}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timeout_err;
  master_id_t grant_id;
  int         total = 0;
  int         bad = 0;

  l2_arbiter_if #(.ADDR_W(32), .DATA_W(256)) m0_if ();
  l2_arbiter_if #(.ADDR_W(32), .DATA_W(256)) m1_if ();
  l2_arbiter_if #(.ADDR_W(32), .DATA_W(256)) l2_if ();

  l2_arbiter #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .l2         (l2_if),
    .timeout_err(timeout_err),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] allOuts();
    return {l2_if.stb, l2_if.cyc, l2_if.write, |l2_if.addr, |l2_if.wdata,
            m0_if.resp, m0_if.retry, |m0_if.rdata,
            m1_if.resp, m1_if.retry, |m1_if.rdata, timeout_err, grant_id};
  endfunction

  task automatic dropAll();
    m0_if.stb = 0; m0_if.cyc = 0; m0_if.write = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.stb = 0; m1_if.cyc = 0; m1_if.write = 0; m1_if.addr = '0; m1_if.wdata = '0;
    l2_if.resp = 0; l2_if.rdata = '0;
  endtask

  task automatic settle();
    dropAll();
    repeat (3) @(negedge clk);
  endtask

  task automatic reqM0(input logic [31:0] a);
    m0_if.stb = 1; m0_if.cyc = 1; m0_if.write = 0; m0_if.addr = a;
  endtask

  task automatic reqM1(input logic [31:0] a);
    m1_if.stb = 1; m1_if.cyc = 1; m1_if.write = 0; m1_if.addr = a;
  endtask

  task automatic test_reset();
    rst_n = 0;
    dropAll();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (allOuts() !== 13'd0) begin
      bad++; $display("[TB] FAIL reset_outs: got %b want 0", allOuts());
    end
    rst_n = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk); reqM0(32'h1000); #1;
    total++;
    if (l2_if.stb !== 1'b0 || m0_if.retry !== 1'b1) begin
      bad++; $display("[TB] FAIL single_idle: stb=%b retry=%b want 0/1", l2_if.stb, m0_if.retry);
    end
    @(negedge clk); #1;
    total++;
    if (l2_if.stb !== 1'b1 || l2_if.addr !== 32'h1000 || grant_id !== M_ICACHE) begin
      bad++; $display("[TB] FAIL single_fwd: stb=%b addr=%h gid=%b want 1/1000/0", l2_if.stb, l2_if.addr, grant_id);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (m0_if.resp !== 1'b0 || l2_if.addr !== 32'h1000) begin
        bad++; $display("[TB] FAIL single_hold: resp=%b addr=%h want 0/1000", m0_if.resp, l2_if.addr);
      end
    end
    @(negedge clk); l2_if.resp = 1; l2_if.rdata = RD_PAT; #1;
    total++;
    if (m0_if.resp !== 1'b1 || m0_if.rdata !== RD_PAT || m0_if.retry !== 1'b0 || m1_if.rdata !== '0) begin
      bad++; $display("[TB] FAIL single_resp: resp=%b retry=%b rdata=%h want 1/0/%h", m0_if.resp, m0_if.retry, m0_if.rdata, RD_PAT);
    end
    @(negedge clk); dropAll(); #1;
    total++;
    if (allOuts() !== 13'd0) begin
      bad++; $display("[TB] FAIL single_release: got %b want 0", allOuts());
    end
    settle();
  endtask

  task automatic test_both_requests();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    reqM0(32'h100); reqM1(32'h200); #1;
    total++;
    if (m1_if.retry !== 1'b1 || l2_if.stb !== 1'b0) begin
      bad++; $display("[TB] FAIL tie_idle: retry1=%b stb=%b want 1/0", m1_if.retry, l2_if.stb);
    end
    @(negedge clk); #1;
    total++;
    if (grant_id !== M_ICACHE || l2_if.addr !== 32'h100 || m1_if.retry !== 1'b1) begin
      bad++; $display("[TB] FAIL tie_first: gid=%b addr=%h retry1=%b want 0/100/1", grant_id, l2_if.addr, m1_if.retry);
    end
    @(negedge clk); l2_if.resp = 1; l2_if.rdata = RD_PAT2; #1;
    total++;
    if (m0_if.resp !== 1'b1 || m0_if.rdata !== RD_PAT2 || m1_if.resp !== 1'b0 || m1_if.retry !== 1'b1 || m1_if.rdata !== '0) begin
      bad++; $display("[TB] FAIL tie_resp: r0=%b r1=%b retry1=%b want 1/0/1", m0_if.resp, m1_if.resp, m1_if.retry);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        l2_if.resp = 0; l2_if.rdata = '0; m0_if.stb = 0; m0_if.cyc = 0;
      end
      #1;
      total++;
      if (l2_if.stb !== 1'b0 || m1_if.retry !== 1'b1) begin
        bad++; $display("[TB] FAIL tie_bubble%0d: stb=%b retry1=%b want 0/1", i, l2_if.stb, m1_if.retry);
      end
    end
    @(negedge clk); #1;
    total++;
    if (l2_if.stb !== 1'b1 || l2_if.addr !== 32'h200 || grant_id !== M_DCACHE) begin
      bad++; $display("[TB] FAIL tie_second: stb=%b addr=%h gid=%b want 1/200/1", l2_if.stb, l2_if.addr, grant_id);
    end
    @(negedge clk); l2_if.resp = 1; #1;
    total++;
    if (m1_if.resp !== 1'b1) begin
      bad++; $display("[TB] FAIL tie_resp1: got %b want 1", m1_if.resp);
    end
    @(negedge clk); dropAll();
    @(negedge clk); reqM0(32'h100); reqM1(32'h200);
    @(negedge clk); #1;
    total++;
    if (grant_id !== M_ICACHE || l2_if.addr !== 32'h100) begin
      bad++; $display("[TB] FAIL tie_third: gid=%b addr=%h want 0/100", grant_id, l2_if.addr);
    end
    settle();
  endtask

  task automatic test_write();
    @(negedge clk);
    m1_if.stb = 1; m1_if.cyc = 1; m1_if.write = 1; m1_if.addr = 32'h2040; m1_if.wdata = WR_PAT;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (l2_if.write !== 1'b1 || l2_if.wdata !== WR_PAT || l2_if.addr !== 32'h2040 || grant_id !== M_DCACHE) begin
        bad++; $display("[TB] FAIL write_fwd%0d: wr=%b addr=%h gid=%b want 1/2040/1", i, l2_if.write, l2_if.addr, grant_id);
      end
    end
    @(negedge clk); l2_if.resp = 1; #1;
    total++;
    if (m1_if.resp !== 1'b1 || l2_if.wdata !== WR_PAT || m0_if.resp !== 1'b0) begin
      bad++; $display("[TB] FAIL write_resp: r1=%b r0=%b want 1/0", m1_if.resp, m0_if.resp);
    end
    @(negedge clk);
    settle();
  endtask

  task automatic test_abort();
    @(negedge clk); reqM0(32'h300); reqM1(32'h400);
    @(negedge clk); #1;
    total++;
    if (grant_id !== M_ICACHE || l2_if.addr !== 32'h300) begin
      bad++; $display("[TB] FAIL abort_grant: gid=%b addr=%h want 0/300", grant_id, l2_if.addr);
    end
    @(negedge clk);
    @(negedge clk); m0_if.stb = 0; m0_if.cyc = 0; #1;
    total++;
    if (l2_if.cyc !== 1'b0 || m0_if.resp !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_drop: cyc=%b resp=%b want 0/0", l2_if.cyc, m0_if.resp);
    end
    @(negedge clk); #1;
    total++;
    if (l2_if.stb !== 1'b0 || l2_if.cyc !== 1'b0 || l2_if.addr !== '0 || m0_if.resp !== 1'b0 || m1_if.retry !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_idle: stb=%b addr=%h resp0=%b retry1=%b want 0/0/0/1", l2_if.stb, l2_if.addr, m0_if.resp, m1_if.retry);
    end
    @(negedge clk); #1;
    total++;
    if (grant_id !== M_DCACHE || l2_if.addr !== 32'h400) begin
      bad++; $display("[TB] FAIL abort_next: gid=%b addr=%h want 1/400", grant_id, l2_if.addr);
    end
    settle();
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); reqM0(32'h500);
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk); #1;
        total++;
        if (timeout_err !== 1'b0 || l2_if.stb !== 1'b1) begin
          bad++; $display("[TB] FAIL wdog_early%0d: err=%b stb=%b want 0/1", k, timeout_err, l2_if.stb);
        end
      end
      @(negedge clk);
      if (pass == 1) l2_if.resp = 1;
      #1;
      total++;
      if (timeout_err !== (pass == 0) || m0_if.resp !== (pass == 1)) begin
        bad++; $display("[TB] FAIL wdog_fire%0d: err=%b resp=%b want %b/%b", pass, timeout_err, m0_if.resp, pass == 0, pass == 1);
      end
      @(negedge clk); l2_if.resp = 0; #1;
      total++;
      if (timeout_err !== 1'b0 || l2_if.stb !== 1'b0 || m0_if.retry !== 1'b1) begin
        bad++; $display("[TB] FAIL wdog_release%0d: err=%b stb=%b retry=%b want 0/0/1", pass, timeout_err, l2_if.stb, m0_if.retry);
      end
      settle();
    end
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk); reqM1(32'h600);
    @(negedge clk); #1;
    total++;
    if (grant_id !== M_DCACHE || l2_if.addr !== 32'h600) begin
      bad++; $display("[TB] FAIL rst_pre: gid=%b addr=%h want 1/600", grant_id, l2_if.addr);
    end
    @(negedge clk); rst_n = 0;
    @(negedge clk); #1;
    total++;
    if ({l2_if.stb, l2_if.cyc, |l2_if.addr, m1_if.resp, timeout_err, grant_id} !== 6'd0) begin
      bad++; $display("[TB] FAIL rst_mid: stb=%b addr=%h resp1=%b gid=%b want 0", l2_if.stb, l2_if.addr, m1_if.resp, grant_id);
    end
    dropAll(); #1;
    total++;
    if (allOuts() !== 13'd0) begin
      bad++; $display("[TB] FAIL rst_all: got %b want 0", allOuts());
    end
    rst_n = 1; reqM0(32'h100); reqM1(32'h200);
    @(negedge clk); #1;
    total++;
    if (grant_id !== M_ICACHE || l2_if.addr !== 32'h100) begin
      bad++; $display("[TB] FAIL rst_tie: gid=%b addr=%h want 0/100", grant_id, l2_if.addr);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both_requests();
    test_write();
    test_abort();
    test_timeout();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
